sc_fifo_ext: RTL and testbench

Single-clock synchronous FIFO, parametrised in data width and depth, with a selectable read mode:
- standard mode: registered read data one cycle after rd;
- show-ahead (first-word-fall-through) mode: head word presented while not empty.

Adds programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and clear-over-access priority. Drop-in buffer for UART TX/RX paths and register-bus bridges.

---
 rtl/sc_fifo_pkg.sv | 13 +
 rtl/sc_fifo_ram.sv | 48 ++++
 rtl/sc_fifo_ext.sv | 141 ++++++++++++++
 tb/tb_sc_fifo_ext.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sc_fifo_pkg.sv
// Shared constants and helpers for the sc_fifo family.
package sc_fifo_pkg;

  // Read-mode selector values for the SHOWAHEAD parameter
  localparam int SC_FIFO_STD       = 0;
  localparam int SC_FIFO_SHOWAHEAD = 1;

  // Word-count width: one extra bit so a completely full FIFO is representable
  function automatic int sc_fifo_cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/sc_fifo_ram.sv
// Simple dual-port storage: synchronous write, async or registered read.
module sc_fifo_ram #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int SYNC_RD = 0
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write port; contents are not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (SYNC_RD != 0) begin : g_sync_rd
      logic [DATA_W-1:0] rdata_d;
      logic [DATA_W-1:0] rdata_q;

      // Read-before-write: a same-edge write to raddr returns the old word
      always_comb begin
        rdata_d = mem[raddr];
      end

      // Registered read port
      always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
      end

      assign rdata = rdata_q;
    end else begin : g_async_rd
      // Combinational read port
      always_comb begin
        rdata = mem[raddr];
      end
    end
  endgenerate

endmodule

// File: rtl/sc_fifo_ext.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// programmable almost flags and sticky overflow/underflow.
module sc_fifo_ext
  import sc_fifo_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int SHOWAHEAD = SC_FIFO_STD
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   use_words,
  input  logic [ADDR_W:0]   afull_thr,
  input  logic [ADDR_W:0]   aempty_thr,
  output logic              overflow,
  output logic              underflow
);

  localparam int              CNT_W = sc_fifo_cnt_w(ADDR_W);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(2 ** ADDR_W);

  logic [CNT_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [CNT_W-1:0] rd_ptr_d, rd_ptr_q;
  logic             overflow_d, overflow_q;
  logic             underflow_d, underflow_q;
  logic             wr_acc, rd_acc;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  // Status flags come straight from the registered pointers
  always_comb begin
    use_words    = wr_ptr_q - rd_ptr_q;
    full         = (use_words == DEPTH_C);
    empty        = (use_words == '0);
    almost_full  = (use_words >= afull_thr);
    almost_empty = (use_words <= aempty_thr);
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  // Access acceptance, pointer advance and sticky error flags; clear wins
  always_comb begin
    wr_acc      = wr & ~full & ~clear;
    rd_acc      = rd & ~empty & ~clear;
    wr_ptr_d    = wr_ptr_q + CNT_W'(wr_acc);
    rd_ptr_d    = rd_ptr_q + CNT_W'(rd_acc);
    overflow_d  = overflow_q | (wr & full & ~clear);
    underflow_d = underflow_q | (rd & empty & ~clear);
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sc_fifo_ram #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .SYNC_RD ((SHOWAHEAD == SC_FIFO_SHOWAHEAD) ? 1 : 0)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  generate
    if (SHOWAHEAD == SC_FIFO_SHOWAHEAD) begin : g_fwft
      logic              byp_d, byp_q;
      logic [DATA_W-1:0] byp_data_q;

      // Prefetch the next head: the sync RAM is addressed with the next read
      // pointer; a write landing on that slot this edge is caught by the bypass
      always_comb begin
        ram_raddr = rd_ptr_d[ADDR_W-1:0];
        byp_d     = wr_acc & (wr_ptr_q[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
      end

      // Bypass select flag
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) byp_q <= 1'b0;
        else          byp_q <= byp_d;
      end

      // Bypass data capture, unreset datapath
      always_ff @(posedge clk) begin
        byp_data_q <= data_in;
      end

      // Head word while not empty; forced to zero when empty so reset reads 0
      always_comb begin
        data_out = '0;
        if (!empty) data_out = byp_q ? byp_data_q : ram_rdata;
      end
    end else begin : g_std
      logic [DATA_W-1:0] data_out_d, data_out_q;

      // Load the head word only on an accepted read, otherwise hold
      always_comb begin
        ram_raddr  = rd_ptr_q[ADDR_W-1:0];
        data_out_d = rd_acc ? ram_rdata : data_out_q;
      end

      // Registered read data
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) data_out_q <= '0;
        else          data_out_q <= data_out_d;
      end

      assign data_out = data_out_q;
    end
  endgenerate

endmodule

// File: tb/tb_sc_fifo_ext.sv
// Directed bench: a standard-mode and a show-ahead instance share stimulus.
module tb_sc_fifo_ext;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear;
  logic          wr;
  logic          rd;
  logic [DW-1:0] data_in;
  logic [AW:0]   afull_thr;
  logic [AW:0]   aempty_thr;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_full, f_full, s_empty, f_empty;
  logic          s_af, f_af, s_ae, f_ae;
  logic [AW:0]   s_cnt, f_cnt;
  logic          s_ovf, f_ovf, s_udf, f_udf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sc_fifo_ext #(.DATA_W(DW), .ADDR_W(AW), .SHOWAHEAD(0)) u_std (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wr(wr), .data_in(data_in),
    .rd(rd), .data_out(s_dout), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .use_words(s_cnt),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr),
    .overflow(s_ovf), .underflow(s_udf)
  );

  sc_fifo_ext #(.DATA_W(DW), .ADDR_W(AW), .SHOWAHEAD(1)) u_fwft (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wr(wr), .data_in(data_in),
    .rd(rd), .data_out(f_dout), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .use_words(f_cnt),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr),
    .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
    wr = w; rd = r; clear = c; data_in = d;
    tick();
    wr = 1'b0; rd = 1'b0; clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; wr = 1'b0; rd = 1'b0; data_in = '0;
    afull_thr = 3'd3; aempty_thr = 3'd1;
    #2;
    // Reset state
    chk("rst_cnt_s", s_cnt, 0);        chk("rst_cnt_f", f_cnt, 0);
    chk("rst_empty_s", s_empty, 1);    chk("rst_empty_f", f_empty, 1);
    chk("rst_full_s", s_full, 0);      chk("rst_ae_s", s_ae, 1);
    chk("rst_af_s", s_af, 0);          chk("rst_dout_s", s_dout, 0);
    chk("rst_dout_f", f_dout, 0);      chk("rst_ovf_s", s_ovf, 0);
    chk("rst_udf_f", f_udf, 0);
    afull_thr = 3'd0; #1;
    chk("rst_af_thr0", s_af, 1);
    afull_thr = 3'd3;
    #9 reset_n = 1'b1;

    // Fill 0->4 with almost-flag checks (thresholds 3/1)
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(8'h11 * i));
      chk("fill_cnt", s_cnt, i);
      chk("fill_ae", s_ae, (i <= 1) ? 1 : 0);
      chk("fill_af", s_af, (i >= 3) ? 1 : 0);
      chk("fill_head_f", f_dout, 8'h11);
    end
    chk("full_s", s_full, 1);
    chk("full_f", f_full, 1);
    drive(1'b1, 1'b0, 1'b0, 8'h55);
    chk("ovf_s", s_ovf, 1);            chk("ovf_f", f_ovf, 1);
    chk("ovf_cnt", s_cnt, 4);

    // Back-to-back reads
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      chk("rd_dout_s", s_dout, 8'(8'h11 * i));
      if (i < 4) chk("rd_head_f", f_dout, 8'(8'h11 * (i + 1)));
    end
    chk("drain_empty_s", s_empty, 1);
    chk("drain_empty_f", f_empty, 1);
    tick();
    chk("hold_dout_s", s_dout, 8'h44);

    // Empty with rd+wr: write accepted, underflow set
    drive(1'b1, 1'b1, 1'b0, 8'h5A);
    chk("udf_s", s_udf, 1);            chk("udf_cnt", s_cnt, 1);
    chk("udf_head_f", f_dout, 8'h5A);  chk("udf_hold_s", s_dout, 8'h44);

    // Clear with rd+wr: flush, error flags cleared, no new error
    drive(1'b1, 1'b1, 1'b1, 8'h77);
    chk("clr_cnt", s_cnt, 0);          chk("clr_empty_f", f_empty, 1);
    chk("clr_ovf", s_ovf, 0);          chk("clr_udf", f_udf, 0);
    chk("clr_hold_s", s_dout, 8'h44);

    // Show-ahead basics
    drive(1'b1, 1'b0, 1'b0, 8'hA5);
    chk("sa_first_f", f_dout, 8'hA5);
    drive(1'b1, 1'b0, 1'b0, 8'hB6);
    chk("sa_keep_f", f_dout, 8'hA5);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk("sa_next_f", f_dout, 8'hB6);   chk("sa_std_s", s_dout, 8'hA5);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk("sa_empty_f", f_empty, 1);     chk("sa_std2_s", s_dout, 8'hB6);

    // One word present, rd+wr together: new word lands on the next head slot
    drive(1'b1, 1'b0, 1'b0, 8'h01);
    drive(1'b1, 1'b1, 1'b0, 8'h02);
    chk("one_rw_f", f_dout, 8'h02);    chk("one_rw_cnt", f_cnt, 1);
    chk("one_rw_s", s_dout, 8'h01);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk("one_rw_tail_s", s_dout, 8'h02);

    // Wrap-around with interleaved write/read pairs
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(i));
      chk("wrap_cnt", s_cnt, 1);       chk("wrap_full_f", f_full, 0);
      chk("wrap_head_f", f_dout, i);
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      chk("wrap_dout_s", s_dout, i);   chk("wrap_empty_f", f_empty, 1);
    end

    // Full with rd+wr: read accepted, write dropped
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    drive(1'b1, 1'b1, 1'b0, 8'h65);
    chk("frw_cnt_s", s_cnt, 3);        chk("frw_cnt_f", f_cnt, 3);
    chk("frw_ovf", s_ovf, 1);          chk("frw_dout_s", s_dout, 8'h61);
    chk("frw_head_f", f_dout, 8'h62);

    // Clear at count 3 with overflow set
    drive(1'b1, 1'b1, 1'b1, 8'h99);
    chk("clr2_cnt", f_cnt, 0);         chk("clr2_empty", s_empty, 1);
    chk("clr2_ovf", f_ovf, 0);         chk("clr2_udf", s_udf, 0);

    // Thresholds above depth
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h70 + i));
    afull_thr = 3'd7; aempty_thr = 3'd5; #1;
    chk("bigthr_af", s_af, 0);         chk("bigthr_ae", f_ae, 1);
    drive(1'b1, 1'b0, 1'b0, 8'hEE);

    // Asynchronous reset mid-cycle
    #2 reset_n = 1'b0;
    #1;
    chk("arst_cnt", s_cnt, 0);         chk("arst_empty_f", f_empty, 1);
    chk("arst_full", s_full, 0);       chk("arst_ovf", f_ovf, 0);
    chk("arst_dout_s", s_dout, 0);     chk("arst_dout_f", f_dout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
